unified_mem_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory between two requesters:
//  - the multi-cycle core (fetch and lw/sw traffic)
//  - a debug/loader port

---
 rtl/unified_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_unified_mem_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one fixed-latency unified memory between the core and a debug port.
// Optional ARB_PERF_EN adds saturating per-port grant counters.
`default_nettype none

module unified_mem_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int MEM_LAT       = 2,
  parameter int MAX_CPU_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic [DW-1:0] o_cpu_rdata,
  output logic          o_cpu_ready,
  input  logic          i_dbg_req,
  input  logic          i_dbg_we,
  input  logic [AW-1:0] i_dbg_addr,
  input  logic [DW-1:0] i_dbg_wdata,
  output logic [DW-1:0] o_dbg_rdata,
  output logic          o_dbg_ready,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_busy,
`ifdef ARB_PERF_EN
  output logic [15:0]   o_cpu_grant_cnt,
  output logic [15:0]   o_dbg_grant_cnt,
`endif
  output logic          o_owner
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(MAX_CPU_BURST + 1);
  localparam logic [LW-1:0] LAT_INIT   = LW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_CPU_BURST);

  logic [1:0]    r_state;
  logic          r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [LW-1:0] r_lat_cnt;
  logic [SW-1:0] r_cpu_streak;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_dbg_rdata;

  logic w_grant_dbg;
  logic w_grant_cpu;
  logic w_idle;
  logic w_last;

  // Debug only overtakes a requesting CPU once the CPU has used its burst allowance.
  assign w_idle      = (r_state == S_IDLE);
  assign w_grant_dbg = w_idle && i_dbg_req && (!i_cpu_req || (r_cpu_streak == STREAK_MAX));
  assign w_grant_cpu = w_idle && i_cpu_req && !w_grant_dbg;
  assign w_last      = (r_lat_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_lat_cnt    <= '0;
      r_cpu_streak <= '0;
      r_cpu_rdata  <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_cpu || w_grant_dbg) begin
            r_owner   <= w_grant_dbg;
            r_we      <= w_grant_dbg ? i_dbg_we    : i_cpu_we;
            r_addr    <= w_grant_dbg ? i_dbg_addr  : i_cpu_addr;
            r_wdata   <= w_grant_dbg ? i_dbg_wdata : i_cpu_wdata;
            r_lat_cnt <= LAT_INIT;
            r_state   <= S_ACCESS;
          end
          if (w_grant_dbg || !i_dbg_req) begin
            r_cpu_streak <= '0;
          end else if (w_grant_cpu && (r_cpu_streak != STREAK_MAX)) begin
            r_cpu_streak <= r_cpu_streak + SW'(1);
          end
        end
        S_ACCESS: begin
          if (w_last) begin
            if (!r_we) begin
              if (r_owner) r_dbg_rdata <= i_mem_rdata;
              else         r_cpu_rdata <= i_mem_rdata;
            end
            r_state <= S_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - LW'(1);
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_cpu_grant_cnt <= '0;
      o_dbg_grant_cnt <= '0;
    end else begin
      if (w_grant_cpu && (o_cpu_grant_cnt != 16'hFFFF)) o_cpu_grant_cnt <= o_cpu_grant_cnt + 16'd1;
      if (w_grant_dbg && (o_dbg_grant_cnt != 16'hFFFF)) o_dbg_grant_cnt <= o_dbg_grant_cnt + 16'd1;
    end
  end
`endif

  // Strobes decode straight from state so an async reset removes them immediately.
  assign o_mem_en    = (r_state == S_ACCESS);
  assign o_mem_we    = o_mem_en && r_we && w_last;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_cpu_ready = (r_state == S_RESP) && !r_owner;
  assign o_dbg_ready = (r_state == S_RESP) &&  r_owner;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_dbg_rdata = r_dbg_rdata;
  assign o_busy      = (r_state == S_ACCESS) || (r_state == S_RESP);
  assign o_owner     = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed vectors for unified_mem_arbiter (MEM_LAT=2, MAX_CPU_BURST=4).
`default_nettype none

module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic [31:0] mem_rdata = '0;
  wire  [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
  wire         cpu_ready, dbg_ready, mem_en, mem_we, busy, owner;
`ifdef ARB_PERF_EN
  wire  [15:0] cpu_gcnt, dbg_gcnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .MAX_CPU_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_ready(cpu_ready),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_rdata(dbg_rdata), .o_dbg_ready(dbg_ready),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_busy(busy),
`ifdef ARB_PERF_EN
    .o_cpu_grant_cnt(cpu_gcnt), .o_dbg_grant_cnt(dbg_gcnt),
`endif
    .o_owner(owner)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request at a negedge and watches it to its ready pulse.
  task automatic run_txn(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int n_en, output int n_we,
                         output int we_at, output int rdy_at, output int n_other,
                         output logic [31:0] wd_seen);
    n_en = 0; n_we = 0; we_at = 0; rdy_at = 0; n_other = 0; wd_seen = '0;
    if (port) begin dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; end
    else      begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mem_en) begin
        n_en++;
        check_eq("mem_addr", mem_addr, addr);
      end
      if (mem_we) begin n_we++; we_at = i; wd_seen = mem_wdata; end
      if (port ? cpu_ready : dbg_ready) n_other++;
      if (port ? dbg_ready : cpu_ready) begin
        rdy_at = i;
        if (port) dbg_req = 0; else cpu_req = 0;
        break;
      end
    end
    if (rdy_at == 0) begin
      check_eq("txn_timeout", 1, 0);
      cpu_req = 0; dbg_req = 0;
    end
  endtask

  initial begin
    int n_en, n_we, we_at, rdy_at, n_other;
    logic [31:0] wd;
    int   evt_n, both_hi, last_cpu_rdy, gap;
    logic exp_seq [6];
    logic got_seq [6];

    // 1: reset held three cycles
    repeat (3) @(negedge clk);
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_owner", owner, 0);
    check_eq("rst_readys", {cpu_ready, dbg_ready}, 0);
    check_eq("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    reset = 0;
    repeat (2) @(negedge clk);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_mem_en", mem_en, 0);

    // 2: CPU read
    mem_rdata = 32'hDEADBEEF;
    run_txn(0, 0, 32'h10, 0, n_en, n_we, we_at, rdy_at, n_other, wd);
    check_eq("t2_en_cycles", n_en, 2);
    check_eq("t2_we_cycles", n_we, 0);
    check_eq("t2_ready_lat", rdy_at, 3);
    check_eq("t2_other_rdy", n_other, 0);
    check_eq("t2_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    check_eq("t2_owner", owner, 0);
    @(negedge clk);
    check_eq("t2_ready_pulse", cpu_ready, 0);

    // 3: debug read then debug write; write leaves dbg_rdata alone
    mem_rdata = 32'hCAFEF00D;
    run_txn(1, 0, 32'h30, 0, n_en, n_we, we_at, rdy_at, n_other, wd);
    check_eq("t3_rd_lat", rdy_at, 3);
    check_eq("t3_dbg_rdata", dbg_rdata, 32'hCAFEF00D);
    check_eq("t3_cpu_rdata_kept", cpu_rdata, 32'hDEADBEEF);
    @(negedge clk);
    mem_rdata = 32'h0BAD0BAD;
    run_txn(1, 1, 32'h20, 32'h12345678, n_en, n_we, we_at, rdy_at, n_other, wd);
    check_eq("t3_en_cycles", n_en, 2);
    check_eq("t3_we_cycles", n_we, 1);
    check_eq("t3_we_at", we_at, 2);
    check_eq("t3_wdata", wd, 32'h12345678);
    check_eq("t3_ready_lat", rdy_at, 3);
    check_eq("t3_owner", owner, 1);
    check_eq("t3_dbg_rdata_kept", dbg_rdata, 32'hCAFEF00D);
    @(negedge clk);

    // 4: simultaneous requests with zero streak
    mem_rdata = 32'h11112222;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h50;
    evt_n = 0; both_hi = 0;
    for (int i = 1; i <= 20 && evt_n < 2; i++) begin
      @(negedge clk);
      if (i == 1) check_eq("t4_first_owner", owner, 0);
      if (cpu_ready && dbg_ready) both_hi++;
      if (cpu_ready) begin check_eq("t4_cpu_rdy_at", i, 3); cpu_req = 0; evt_n++; end
      if (dbg_ready) begin check_eq("t4_dbg_rdy_at", i, 7); dbg_req = 0; evt_n++; end
    end
    check_eq("t4_events", evt_n, 2);
    check_eq("t4_dbg_rdata", dbg_rdata, 32'h11112222);
    cpu_req = 0; dbg_req = 0;
    @(negedge clk);

    // 5: CPU streams while debug waits: four CPU grants, one debug, then CPU
    exp_seq = '{0, 0, 0, 0, 1, 0};
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h80;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h90;
    evt_n = 0; both_hi = 0; last_cpu_rdy = 0; gap = 0;
    for (int i = 1; i <= 60 && evt_n < 6; i++) begin
      @(negedge clk);
      if (cpu_ready && dbg_ready) both_hi++;
      if (cpu_ready || dbg_ready) begin
        got_seq[evt_n] = dbg_ready;
        evt_n++;
        if (dbg_ready) dbg_req = 0;
        if (cpu_ready) begin
          if (last_cpu_rdy != 0 && gap == 0) gap = i - last_cpu_rdy;
          last_cpu_rdy = i;
        end
      end
    end
    cpu_req = 0; dbg_req = 0;
    check_eq("t5_events", evt_n, 6);
    for (int k = 0; k < 6; k++)
      check_eq($sformatf("t5_grant%0d_owner", k), got_seq[k], exp_seq[k]);
    check_eq("t5_cpu_spacing", gap, 4);
    check_eq("t5_both_ready", both_hi, 0);
    repeat (2) @(negedge clk);

    // 6: async reset during the first ACCESS cycle
    mem_rdata = 32'h77777777;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h60;
    @(negedge clk);
    check_eq("t6_in_access", mem_en, 1);
    reset = 1;
    #1;
    check_eq("t6_mem_en_drop", mem_en, 0);
    check_eq("t6_busy_drop", busy, 0);
    cpu_req = 0;
    n_other = 0;
    repeat (3) begin @(negedge clk); if (cpu_ready) n_other++; end
    check_eq("t6_no_ready", n_other, 0);
    check_eq("t6_rdata_cleared", cpu_rdata, 0);
    reset = 0;
    @(negedge clk);
    mem_rdata = 32'h5A5A5A5A;
    run_txn(0, 0, 32'h70, 0, n_en, n_we, we_at, rdy_at, n_other, wd);
    check_eq("t6_after_lat", rdy_at, 3);
    check_eq("t6_after_rdata", cpu_rdata, 32'h5A5A5A5A);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
